// File: rtl/odu_sched_pkg.sv
// Shared constants and FSM state encoding for the ODU channel-ID scheduler.
package odu_sched_pkg;

  localparam int NUM_CH         = 80;
  localparam int CHID_W         = 7;
  localparam int DATA_WIDTH_CFG = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    BUSY  = 2'd3
  } state_t;

endpackage

// File: rtl/odu_chid_ptr.sv
// Round-robin channel pointer with wrap detection and saturating pass counter.
module odu_chid_ptr
  import odu_sched_pkg::*;
#(
  parameter int NUM_CH = odu_sched_pkg::NUM_CH,
  parameter int CHID_W = odu_sched_pkg::CHID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [CHID_W-1:0] ptr,
  output logic              wrap,
  output logic [15:0]       pass_cnt
);

  localparam logic [CHID_W-1:0] LAST_CH = CHID_W'(NUM_CH - 1);

  assign wrap = advance && (ptr == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      pass_cnt <= '0;
    end else if (clear) begin
      ptr      <= '0;
      pass_cnt <= '0;
    end else if (advance) begin
      if (wrap) begin
        ptr <= '0;
        if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
      end else begin
        ptr <= ptr + CHID_W'(1);
      end
    end
  end

endmodule

// File: rtl/odu_chid_scheduler.sv
// Walks enabled channel IDs round-robin, issuing each to the data generator
// over valid/ready and waiting for burst completion before moving on.
module odu_chid_scheduler
  import odu_sched_pkg::*;
#(
  parameter int NUM_CH         = odu_sched_pkg::NUM_CH,
  parameter int CHID_W         = odu_sched_pkg::CHID_W,
  parameter int DATA_WIDTH_CFG = odu_sched_pkg::DATA_WIDTH_CFG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_start_reg,
  input  logic [NUM_CH-1:0]         cfg_enable,
  input  logic [NUM_CH-1:0]         cfg_type,
  output logic                      sched_valid,
  input  logic                      sched_ready,
  output logic [CHID_W-1:0]         sched_chid,
  output logic                      sched_type,
  input  logic                      gen_done,
  input  logic                      gen_error,
  output logic                      status_gen_data,
  output logic [NUM_CH-1:0]         error_chid,
  output logic [15:0]               pass_cnt
);

  state_t              state;
  logic                run;
  logic                run_q;
  logic                start_rise;
  logic [NUM_CH-1:0]   shadow_en;
  logic [NUM_CH-1:0]   shadow_type;
  logic [CHID_W-1:0]   ptr;
  logic                wrap;
  logic                ptr_clear;
  logic                advance;

  assign run        = cfg_start_reg[0];
  assign start_rise = run & ~run_q;

  // An all-zero mask on start leaves the block completely untouched.
  assign ptr_clear = (state == IDLE) && start_rise && (|cfg_enable);
  assign advance   = ((state == SCAN) && run && !shadow_en[ptr]) ||
                     ((state == BUSY) && gen_done && run);

  assign status_gen_data = (state != IDLE);

  odu_chid_ptr #(
    .NUM_CH (NUM_CH),
    .CHID_W (CHID_W)
  ) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ptr_clear),
    .advance  (advance),
    .ptr      (ptr),
    .wrap     (wrap),
    .pass_cnt (pass_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_q       <= 1'b0;
      shadow_en   <= '0;
      shadow_type <= '0;
      sched_valid <= 1'b0;
      sched_chid  <= '0;
      sched_type  <= 1'b0;
      error_chid  <= '0;
    end else begin
      run_q <= run;
      case (state)
        IDLE: begin
          if (start_rise && (|cfg_enable)) begin
            shadow_en   <= cfg_enable;
            shadow_type <= cfg_type;
            error_chid  <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (!run) begin
            state <= IDLE;
          end else if (shadow_en[ptr]) begin
            state       <= ISSUE;
            sched_valid <= 1'b1;
            sched_chid  <= ptr;
            sched_type  <= shadow_type[ptr];
          end else if (wrap) begin
            // Config changes are only picked up at pass boundaries.
            shadow_en   <= cfg_enable;
            shadow_type <= cfg_type;
            if (cfg_enable == '0) state <= IDLE;
          end
        end
        ISSUE: begin
          if (sched_ready) begin
            sched_valid <= 1'b0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (gen_done) begin
            if (gen_error) error_chid[sched_chid] <= 1'b1;
            if (!run) begin
              state <= IDLE;
            end else if (wrap) begin
              shadow_en   <= cfg_enable;
              shadow_type <= cfg_type;
              state       <= (cfg_enable == '0) ? IDLE : SCAN;
            end else begin
              state <= SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_odu_chid_scheduler.sv
// Directed self-checking bench for odu_chid_scheduler: vector table plus
// hand-written handshake, error, config-change and reset sequences.
module tb_odu_chid_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_start_reg = 16'hA5A4;
  logic [79:0] cfg_enable = '0;
  logic [79:0] cfg_type = '0;
  logic        sched_valid;
  logic        sched_ready = 1'b0;
  logic [6:0]  sched_chid;
  logic        sched_type;
  logic        gen_done = 1'b0;
  logic        gen_error = 1'b0;
  logic        status_gen_data;
  logic [79:0] error_chid;
  logic [15:0] pass_cnt;

  int checks = 0;
  int passed = 0;
  int gap_off = 0;

  always #5 clk = ~clk;

  odu_chid_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start_reg   (cfg_start_reg),
    .cfg_enable      (cfg_enable),
    .cfg_type        (cfg_type),
    .sched_valid     (sched_valid),
    .sched_ready     (sched_ready),
    .sched_chid      (sched_chid),
    .sched_type      (sched_type),
    .gen_done        (gen_done),
    .gen_error       (gen_error),
    .status_gen_data (status_gen_data),
    .error_chid      (error_chid),
    .pass_cnt        (pass_cnt)
  );

  typedef struct {
    logic [79:0] en;
    logic [79:0] ty;
    int          chid;
    bit          typ;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upper bits of the start register are noise the DUT must ignore.
  task automatic set_run(input bit r);
    cfg_start_reg = 16'hA5A4 | {15'd0, r};
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!sched_valid && n < 300) begin
      tick();
      n++;
    end
    if (!sched_valid) begin
      checks++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected sched_valid=1", n);
    end
  endtask

  task automatic serve(input int chid, input bit typ, input int gap, input bit err,
                       input int pass_exp, input bit stop);
    int n;
    wait_valid(n);
    $display("issue chid=%0d type=%0d gap=%0d", sched_chid, sched_type, n + gap_off);
    chk("issue_chid", 80'(sched_chid), 80'(chid));
    chk("issue_type", 80'(sched_type), 80'(typ));
    chk("issue_gap", 80'(n + gap_off), 80'(gap));
    tick();
    chk("valid_drop", 80'(sched_valid), 80'(0));
    tick();
    tick();
    gen_done = 1'b1;
    gen_error = err;
    if (stop) set_run(1'b0);
    tick();
    gen_done = 1'b0;
    gen_error = 1'b0;
    chk("pass_cnt", 80'(pass_cnt), 80'(pass_exp));
    gap_off = 1;
    if (stop) chk("stop_idle", 80'(status_gen_data), 80'(0));
  endtask

  initial begin
    int n;
    logic [79:0] exp_err;

    vecs[0] = '{en: 80'd1,        ty: 80'd1,        chid: 0,  typ: 1'b1, lat: 2};
    vecs[1] = '{en: 80'd1 << 5,   ty: 80'd1 << 5,   chid: 5,  typ: 1'b1, lat: 7};
    vecs[2] = '{en: 80'd1 << 79,  ty: 80'd0,        chid: 79, typ: 1'b0, lat: 81};
    vecs[3] = '{en: (80'd1 << 40) | (80'd1 << 41), ty: 80'd1 << 41, chid: 40, typ: 1'b0, lat: 42};
    vecs[4] = '{en: ~80'd0,       ty: 80'd0,        chid: 0,  typ: 1'b0, lat: 2};

    // Reset state
    tick();
    tick();
    chk("rst_valid", 80'(sched_valid), 80'(0));
    chk("rst_status", 80'(status_gen_data), 80'(0));
    chk("rst_error", error_chid, 80'(0));
    chk("rst_pass", 80'(pass_cnt), 80'(0));
    rst_n = 1'b1;
    tick();

    // First-issue latency and chid/type selection
    for (int i = 0; i < 5; i++) begin
      cfg_enable = vecs[i].en;
      cfg_type = vecs[i].ty;
      sched_ready = 1'b0;
      set_run(1'b1);
      wait_valid(n);
      $display("vector %0d chid=%0d type=%0d latency=%0d", i, sched_chid, sched_type, n);
      chk("vec_chid", 80'(sched_chid), 80'(vecs[i].chid));
      chk("vec_type", 80'(sched_type), 80'(vecs[i].typ));
      chk("vec_latency", 80'(n), 80'(vecs[i].lat));
      chk("vec_status", 80'(status_gen_data), 80'(1));
      set_run(1'b0);
      sched_ready = 1'b1;
      tick();
      sched_ready = 1'b0;
      chk("vec_valid_drop", 80'(sched_valid), 80'(0));
      gen_done = 1'b1;
      tick();
      gen_done = 1'b0;
      chk("vec_idle", 80'(status_gen_data), 80'(0));
    end

    // Round-robin order across a pass boundary
    cfg_enable = (80'd1) | (80'd1 << 40) | (80'd1 << 79);
    cfg_type = '0;
    sched_ready = 1'b1;
    gap_off = 0;
    set_run(1'b1);
    serve(0, 1'b0, 2, 1'b0, 0, 1'b0);
    serve(40, 1'b0, 41, 1'b0, 0, 1'b0);
    serve(79, 1'b0, 40, 1'b0, 1, 1'b0);
    serve(0, 1'b0, 2, 1'b0, 1, 1'b1);

    // Single channel repeats once per pass
    cfg_enable = 80'd1 << 5;
    cfg_type = 80'd1 << 5;
    gap_off = 0;
    set_run(1'b1);
    serve(5, 1'b1, 7, 1'b0, 0, 1'b0);
    serve(5, 1'b1, 81, 1'b0, 1, 1'b0);
    serve(5, 1'b1, 81, 1'b0, 2, 1'b1);

    // Backpressure with run dropped while valid is pending
    cfg_enable = 80'd1 << 7;
    cfg_type = '0;
    sched_ready = 1'b0;
    set_run(1'b1);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) set_run(1'b0);
      tick();
      chk("bp_valid", 80'(sched_valid), 80'(1));
      chk("bp_chid", 80'(sched_chid), 80'(7));
    end
    sched_ready = 1'b1;
    tick();
    sched_ready = 1'b0;
    chk("bp_valid_drop", 80'(sched_valid), 80'(0));
    chk("bp_busy", 80'(status_gen_data), 80'(1));
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk("bp_idle", 80'(status_gen_data), 80'(0));

    // Sticky error flags, cleared by the next start
    cfg_enable = (80'd1 << 17) | (80'd1 << 64);
    sched_ready = 1'b1;
    gap_off = 0;
    set_run(1'b1);
    serve(17, 1'b0, 19, 1'b1, 0, 1'b0);
    serve(64, 1'b0, 48, 1'b1, 0, 1'b1);
    exp_err = (80'd1 << 17) | (80'd1 << 64);
    chk("err_vec", error_chid, exp_err);
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky", error_chid, exp_err);
    set_run(1'b1);
    tick();
    chk("err_cleared", error_chid, 80'(0));
    chk("err_pass_cleared", 80'(pass_cnt), 80'(0));
    chk("err_restart", 80'(status_gen_data), 80'(1));
    set_run(1'b0);
    tick();
    chk("err_stop", 80'(status_gen_data), 80'(0));

    // Mid-pass config change only lands after the wrap
    cfg_enable = 80'd1 << 3;
    set_run(1'b1);
    wait_valid(n);
    chk("cfg_first_chid", 80'(sched_chid), 80'(3));
    tick();
    cfg_enable = 80'd1 << 9;
    tick();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    gap_off = 1;
    serve(9, 1'b0, 87, 1'b0, 1, 1'b1);

    // Asynchronous reset while BUSY
    cfg_enable = 80'd1 << 2;
    set_run(1'b1);
    wait_valid(n);
    tick();
    gen_error = 1'b1;
    gen_done = 1'b1;
    #2;
    rst_n = 1'b0;
    gen_done = 1'b0;
    gen_error = 1'b0;
    #1;
    chk("arst_valid", 80'(sched_valid), 80'(0));
    chk("arst_chid", 80'(sched_chid), 80'(0));
    chk("arst_type", 80'(sched_type), 80'(0));
    chk("arst_status", 80'(status_gen_data), 80'(0));
    chk("arst_error", error_chid, 80'(0));
    chk("arst_pass", 80'(pass_cnt), 80'(0));
    set_run(1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    gen_done = 1'b1;
    gen_error = 1'b1;
    tick();
    gen_done = 1'b0;
    gen_error = 1'b0;
    chk("arst_done_ignored", 80'(status_gen_data), 80'(0));
    chk("arst_err_ignored", error_chid, 80'(0));

    // Zero-mask start stays idle
    cfg_enable = '0;
    set_run(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zero_mask_idle", 80'(status_gen_data), 80'(0));
    end
    chk("zero_mask_valid", 80'(sched_valid), 80'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/odu_chid_scheduler.md
Name: odu_chid_scheduler

Overview:
- Sequences the ODU data generator across 80 channel IDs.
- Consumes the enable/type/start values held by the configuration register block, then walks the enabled channels in round-robin order. It issues one channel at a time to the generator over a valid/ready handshake and waits for burst completion before moving on.
- Drives the generator status bit and the 80-bit sticky per-channel error vector back into the configuration block.

Parameters:
- NUM_CH, 80, number of channel IDs scheduled.
- CHID_W, 7, width of channel ID (ceil(log2(NUM_CH))).
- DATA_WIDTH_CFG, 16, width of the config start register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start_reg  in  DATA_WIDTH_CFG  start register; bit0 = run, other bits ignored.
- cfg_enable  in  NUM_CH  per-channel enable mask, bit i = chid i.
- cfg_type  in  NUM_CH  per-channel data type, bit i = chid i.
- sched_valid  out  1  channel issue request to the generator.
- sched_ready  in  1  generator accepts the issued channel.
- sched_chid  out  CHID_W  issued channel ID.
- sched_type  out  1  type bit of the issued channel.
- gen_done  in  1  single-cycle pulse: burst for the accepted channel has finished.
- gen_error  in  1  qualified by gen_done: burst ended in error.
- status_gen_data  out  1  1 whenever the scheduler is not IDLE.
- error_chid  out  NUM_CH  sticky error flags, bit i = chid i.
- pass_cnt  out  16  completed full passes over all channels, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=0, run_q=0, shadow enable/type=0.
  - All outputs 0: sched_valid, sched_chid, sched_type, status_gen_data, error_chid, pass_cnt.
  - Reset asserted mid-burst aborts immediately; gen_done arriving after reset release is ignored (state IDLE).
- run_q is a register of cfg_start_reg[0]. start_rise = cfg_start_reg[0] & ~run_q.
- IDLE, on start_rise:
  - Snapshot cfg_enable/cfg_type into shadow registers.
  - Clear error_chid and pass_cnt; set ptr=0.
  - Go to SCAN only if cfg_enable is non-zero; an all-zero mask stays in IDLE with no other effect.
- SCAN, one channel examined per cycle:
  - run=0 -> IDLE; ptr is held.
  - Else if shadow_en[ptr]=1 -> ISSUE, with sched_chid=ptr and sched_type=shadow_type[ptr] registered on the same edge.
  - Else advance ptr.
- ISSUE:
  - sched_valid=1; chid and type are held stable until sched_valid & sched_ready.
  - Valid never drops without ready, even if run falls.
  - On the handshake -> BUSY, and sched_valid=0 on the next cycle.
- BUSY:
  - Waits for gen_done. On gen_done, if gen_error=1, set error_chid[sched_chid].
  - Then: if run=0 -> IDLE, else advance ptr and go to SCAN.
  - gen_done outside BUSY is ignored.
- Advance rule:
  - ptr<NUM_CH-1 -> ptr+1.
  - ptr=NUM_CH-1 -> ptr=0, pass_cnt+1 (saturates at 16'hFFFF), and re-snapshot cfg_enable/cfg_type. Config changes take effect only at pass boundaries.
  - If the re-snapshot mask is all zero -> IDLE.
- Latency: start_rise on edge k gives SCAN at k+1. With chid0 enabled, sched_valid=1 from k+2.
  - Minimum gap between gen_done and the next sched_valid: 2 cycles (SCAN at the next channel, then ISSUE), plus 1 cycle per skipped disabled channel.
- Falling edge of run while IDLE: no effect. A rise while not IDLE: ignored.
- error_chid is retained in IDLE for readback and cleared only by a start_rise or reset.

Decomposition:
- Package odu_sched_pkg: NUM_CH, CHID_W constants and the state enum (IDLE, SCAN, ISSUE, BUSY).
- One sub-module, odu_chid_ptr: ptr register, advance/wrap, wrap pulse, saturating pass_cnt.
- FSM, shadow registers and error vector live in the top.

Test Plan:
- Single channel: enable=1<<5, type=1<<5, run 0->1, ready tied 1, gen_done 3 cycles after accept -> sched_chid=5, sched_type=1; repeats each pass; pass_cnt increments once per 80-channel walk.
- Round-robin order: enable bits {0,40,79}, type=0 -> issue order 0,40,79,0; pass_cnt=1 after the first 79 completes; gap 0->40 is 2+39 cycles after gen_done.
- Handshake backpressure: ready held low 10 cycles, run dropped during the wait -> valid stays 1 with chid stable; after accept and gen_done -> IDLE, status_gen_data=0.
- Errors: gen_done+gen_error on chid 17 and chid 64 -> error_chid has exactly bits 17 and 64 set, sticky after stop; a new start_rise clears it to 0.
- Mid-pass config change: enable changed from bit 3 to bit 9 while chid 3 is BUSY -> chid 3 continues this pass; chid 9 is first issued after the wrap.
- Async reset asserted in BUSY, plus zero-mask start -> all outputs 0 immediately, gen_done after release ignored; start with enable=0 -> status_gen_data stays 0.
